// File: rtl/imem_responder.sv
// imem_responder: memory end of the imemreq/imemresp fetch interface.
// Accepted requests read the word array on the accept edge. The read data
// passes through LATENCY-1 delay stages and then enters an in-order response
// queue. The core drains that queue through imemresp_val/imemresp_rdy.
// Optional build macro: IMEM_RESPONDER_RANDOM_STALL_EN adds an LFSR that
// randomly withholds imemreq_rdy, to stress the requester's handshake.
module imem_responder #(
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 1,
    parameter int QDEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imemreq_val,
    output logic        imemreq_rdy,
    input  logic [31:0] imemreq_addr,
    output logic        imemresp_val,
    input  logic        imemresp_rdy,
    output logic [31:0] imemresp_data,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        err
);

    localparam int AW = $clog2(NUM_WORDS);
    localparam int QW = $clog2(QDEPTH);
    localparam int CW = QW + 1;

    logic [31:0]   mem_q [NUM_WORDS];

    logic          run_q, run_d;
    logic [CW-1:0] outst_q, outst_d;
    logic          err_q, err_d;
    logic [31:0]   fifo_q [QDEPTH];
    logic [31:0]   fifo_d [QDEPTH];
    logic [QW-1:0] wr_ptr_q, wr_ptr_d;
    logic [QW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fcnt_q, fcnt_d;

    logic          stall;
    logic          req_rdy;
    logic          accept;
    logic          deq;
    logic          resp_val;
    logic          req_oob;
    logic          req_mis;
    logic          load_oob;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] load_idx;
    logic [31:0]   rd_word;
    logic          enq_val;
    logic [31:0]   enq_data;
    logic          unused_load_lsb;

    assign req_idx  = imemreq_addr[AW+1:2];
    assign req_oob  = |imemreq_addr[31:AW+2];
    assign req_mis  = |imemreq_addr[1:0];
    assign load_idx = load_addr[AW+1:2];
    assign load_oob = |load_addr[31:AW+2];
    // Loads are word-granular; the byte offset bits carry no meaning.
    assign unused_load_lsb = ^load_addr[1:0];

`ifdef IMEM_RESPONDER_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; advances every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR state register, reseeded on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= lfsr_d;
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    // Readiness is count-based: a same-cycle dequeue frees a slot only next cycle.
    assign req_rdy = run_q & (outst_q < CW'(QDEPTH)) & ~stall;
    assign accept  = imemreq_val & req_rdy;
    assign rd_word = req_oob ? 32'h0000_0000 : mem_q[req_idx];

    generate
        if (LATENCY == 1) begin : g_no_delay
            assign enq_val  = accept;
            assign enq_data = rd_word;
        end else begin : g_delay
            localparam int ND = LATENCY - 1;
            logic        dv_q [ND];
            logic        dv_d [ND];
            logic [31:0] dd_q [ND];
            logic [31:0] dd_d [ND];

            // Shift the accepted read through the fixed-latency delay line.
            always_comb begin
                dv_d[0] = accept;
                dd_d[0] = accept ? rd_word : 32'h0000_0000;
                for (int i = 1; i < ND; i++) begin
                    dv_d[i] = dv_q[i-1];
                    dd_d[i] = dd_q[i-1];
                end
            end

            // Delay line registers; reset discards in-flight reads.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < ND; i++) begin
                        dv_q[i] <= 1'b0;
                        dd_q[i] <= 32'h0000_0000;
                    end
                end else begin
                    for (int i = 0; i < ND; i++) begin
                        dv_q[i] <= dv_d[i];
                        dd_q[i] <= dd_d[i];
                    end
                end
            end

            assign enq_val  = dv_q[ND-1];
            assign enq_data = dd_q[ND-1];
        end
    endgenerate

    assign resp_val = (fcnt_q != '0);
    assign deq      = resp_val & imemresp_rdy;

    // Next-state for outstanding count, response queue and sticky error.
    always_comb begin
        run_d    = 1'b1;
        outst_d  = outst_q + CW'(accept) - CW'(deq);
        err_d    = err_q | (accept & (req_oob | req_mis));
        fifo_d   = fifo_q;
        if (enq_val) fifo_d[wr_ptr_q] = enq_data;
        wr_ptr_d = wr_ptr_q + QW'(enq_val);
        rd_ptr_d = rd_ptr_q + QW'(deq);
        fcnt_d   = fcnt_q + CW'(enq_val) - CW'(deq);
    end

    // Control and queue registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= 1'b0;
            outst_q  <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= 32'h0000_0000;
        end else begin
            run_q    <= run_d;
            outst_q  <= outst_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
            for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= fifo_d[i];
        end
    end

    // Word array: no reset so contents survive it; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (load_en && !load_oob) mem_q[load_idx] <= load_data;
    end

    assign imemreq_rdy   = req_rdy;
    assign imemresp_val  = resp_val;
    assign imemresp_data = resp_val ? fifo_q[rd_ptr_q] : 32'h0000_0000;
    assign err           = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (LATENCY 1 and 3) share the stimulus.
// A transaction-level model (expected-response queues with visibility times)
// is compared against both instances every cycle, plus literal spot checks.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic        imemresp_rdy;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic        rdy_o  [2];
    logic        val_o  [2];
    logic [31:0] data_o [2];
    logic        err_o  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_responder #(.NUM_WORDS(256), .LATENCY(1), .QDEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_rdy(rdy_o[0]), .imemreq_addr(imemreq_addr),
        .imemresp_val(val_o[0]), .imemresp_rdy(imemresp_rdy), .imemresp_data(data_o[0]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .err(err_o[0])
    );

    imem_responder #(.NUM_WORDS(256), .LATENCY(3), .QDEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .imemreq_val(imemreq_val), .imemreq_rdy(rdy_o[1]), .imemreq_addr(imemreq_addr),
        .imemresp_val(val_o[1]), .imemresp_rdy(imemresp_rdy), .imemresp_data(data_o[1]),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .err(err_o[1])
    );

    // ---------------- model ----------------
    logic [31:0] mem_m [256];
    logic [31:0] qd [2][$];
    int          qv [2][$];
    bit          err_m [2];
    bit          run_m = 1'b0;
    int          cyc = 0;
    bit          rdy_b [2];
    bit          val_b [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit exp_val(input int d);
        return (qd[d].size() != 0) && (qv[d][0] <= cyc);
    endfunction

    function automatic bit exp_rdy(input int d);
        return run_m && (qd[d].size() < 4);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a >= 32'd1024) return 32'h0000_0000;
        return mem_m[a[9:2]];
    endfunction

    always @(negedge rst) begin
        for (int d = 0; d < 2; d++) begin
            qd[d].delete();
            qv[d].delete();
            err_m[d] = 1'b0;
        end
        run_m = 1'b0;
    end

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            for (int d = 0; d < 2; d++) begin
                rdy_b[d] = exp_rdy(d);
                val_b[d] = exp_val(d);
            end
            cyc = cyc + 1;
            for (int d = 0; d < 2; d++) begin
                if (val_b[d] && imemresp_rdy) begin
                    void'(qd[d].pop_front());
                    void'(qv[d].pop_front());
                end
                if (imemreq_val && rdy_b[d]) begin
                    qd[d].push_back(model_read(imemreq_addr));
                    qv[d].push_back(cyc + lat_of(d) - 1);
                    if (imemreq_addr[1:0] != 2'b00 || imemreq_addr >= 32'd1024) err_m[d] = 1'b1;
                end
            end
            if (load_en && load_addr < 32'd1024) mem_m[load_addr[9:2]] = load_data;
            run_m = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cyc%0d dut%0d rdy", cyc, d), {31'b0, rdy_o[d]}, {31'b0, exp_rdy(d)});
            chk($sformatf("cyc%0d dut%0d val", cyc, d), {31'b0, val_o[d]}, {31'b0, exp_val(d)});
            chk($sformatf("cyc%0d dut%0d data", cyc, d), data_o[d],
                exp_val(d) ? qd[d][0] : 32'h0000_0000);
            chk($sformatf("cyc%0d dut%0d err", cyc, d), {31'b0, err_o[d]}, {31'b0, err_m[d]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        imemreq_val  = 1'b0;
        imemresp_rdy = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b0;
        imemreq_val = 1'b0; imemreq_addr = '0; imemresp_rdy = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        step();
        chk("reset rdy",  {31'b0, rdy_o[0]}, 32'd0);
        chk("reset val",  {31'b0, val_o[0]}, 32'd0);
        chk("reset data", data_o[0], 32'd0);
        chk("reset err",  {31'b0, err_o[0]}, 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("post-reset rdy", {31'b0, rdy_o[0]}, 32'd1);

        // Fill array with a pattern; byte offsets in load_addr must be ignored.
        for (int i = 0; i < 256; i++) begin
            load_en   = 1'b1;
            load_addr = (i * 4) | (i & 3);
            load_data = 32'hA5A5_0000 | i;
            step();
        end
        load_en = 1'b0;

        // Test 1: load 0x13 at 0, fetch it with LATENCY 1.
        load_en = 1'b1; load_addr = 32'h0; load_data = 32'h0000_0013;
        step();
        load_en = 1'b0;
        imemreq_val = 1'b1; imemreq_addr = 32'h0; imemresp_rdy = 1'b1;
        step();
        imemreq_val = 1'b0;
        chk("t1 val", {31'b0, val_o[0]}, 32'd1);
        chk("t1 data", data_o[0], 32'h0000_0013);
        idle(6);

        // Test 2: four back-to-back requests with back-pressure.
        imemresp_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            imemreq_val = 1'b1; imemreq_addr = k * 4;
            step();
        end
        imemreq_val = 1'b0;
        chk("t2 full rdy", {31'b0, rdy_o[0]}, 32'd0);
        chk("t2 head", data_o[0], 32'h0000_0013);
        imemresp_rdy = 1'b1;
        step();
        chk("t2 rdy back", {31'b0, rdy_o[0]}, 32'd1);
        chk("t2 w1", data_o[0], 32'hA5A5_0001);
        step();
        chk("t2 w2", data_o[0], 32'hA5A5_0002);
        step();
        chk("t2 w3", data_o[0], 32'hA5A5_0003);
        step();
        chk("t2 empty", {31'b0, val_o[0]}, 32'd0);
        idle(8);

        // Test 3: LATENCY 3 instance timing and hold under back-pressure.
        imemresp_rdy = 1'b0;
        imemreq_val = 1'b1; imemreq_addr = 32'h10;
        step();
        imemreq_val = 1'b0;
        chk("t3 lat3 t", {31'b0, val_o[1]}, 32'd0);
        step();
        chk("t3 lat3 t+1", {31'b0, val_o[1]}, 32'd0);
        step();
        chk("t3 lat3 t+2 val", {31'b0, val_o[1]}, 32'd1);
        chk("t3 lat3 t+2 data", data_o[1], 32'hA5A5_0004);
        step();
        chk("t3 hold data", data_o[1], 32'hA5A5_0004);
        step();
        chk("t3 hold val", {31'b0, val_o[1]}, 32'd1);
        idle(6);

        // Test 4: misaligned and out-of-range fetches.
        imemreq_val = 1'b1; imemreq_addr = 32'h6;
        step();
        imemreq_val = 1'b0;
        chk("t4 mis data", data_o[0], 32'hA5A5_0001);
        chk("t4 mis err", {31'b0, err_o[0]}, 32'd1);
        imemreq_val = 1'b1; imemreq_addr = 32'h400;
        step();
        imemreq_val = 1'b0;
        chk("t4 oob data", data_o[0], 32'h0);
        chk("t4 oob val", {31'b0, val_o[0]}, 32'd1);
        idle(6);

        // Test 5: read-before-write, plus a dropped out-of-range load.
        load_en = 1'b1; load_addr = 32'h20; load_data = 32'hDEAD_BEEF;
        imemreq_val = 1'b1; imemreq_addr = 32'h20;
        step();
        load_en = 1'b0; imemreq_val = 1'b0;
        chk("t5 old word", data_o[0], 32'hA5A5_0008);
        idle(4);
        imemreq_val = 1'b1; imemreq_addr = 32'h20;
        step();
        imemreq_val = 1'b0;
        chk("t5 new word", data_o[0], 32'hDEAD_BEEF);
        load_en = 1'b1; load_addr = 32'h400; load_data = 32'h0BAD_0BAD;
        step();
        load_en = 1'b0;
        imemreq_val = 1'b1; imemreq_addr = 32'h0;
        step();
        imemreq_val = 1'b0;
        chk("t5 oob load dropped", data_o[0], 32'h0000_0013);
        idle(6);

        // Test 6: reset with three responses outstanding.
        imemresp_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            imemreq_val = 1'b1; imemreq_addr = k * 4;
            step();
        end
        imemreq_val = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t6 dut%0d rst val", d), {31'b0, val_o[d]}, 32'd0);
            chk($sformatf("t6 dut%0d rst err", d), {31'b0, err_o[d]}, 32'd0);
            chk($sformatf("t6 dut%0d rst rdy", d), {31'b0, rdy_o[d]}, 32'd0);
            chk($sformatf("t6 dut%0d rst data", d), data_o[d], 32'd0);
        end
        step();
        step();
        rst = 1'b1;
        step();
        chk("t6 rdy after release", {31'b0, rdy_o[0]}, 32'd1);
        chk("t6 no stale", {31'b0, val_o[0]}, 32'd0);
        idle(4);
        imemreq_val = 1'b1; imemreq_addr = 32'h20;
        step();
        imemreq_val = 1'b0;
        chk("t6 array kept", data_o[0], 32'hDEAD_BEEF);
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
